// File: rtl/a1335_poll_array.sv
// Round-robin poller for up to NUM_SENSORS A1335 angle sensors sharing one i2c_master.
// Optional feature macro: A1335_STATUS_READ_EN adds a status-register read after each angle read.
module a1335_poll_array #(
  parameter int         NUM_SENSORS    = 4,
  parameter int         POLL_PERIOD    = 50000,
  parameter int         TIMEOUT_CYCLES = 20000,
  parameter logic [7:0] ANGLE_REG      = 8'h20,
  parameter logic [7:0] STATUS_REG     = 8'h22
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      free_run,
  input  logic                      trigger,
  input  logic [NUM_SENSORS-1:0]    sensor_mask,
  input  logic [7*NUM_SENSORS-1:0]  device_ids,
  output logic [16*NUM_SENSORS-1:0] angles,
`ifdef A1335_STATUS_READ_EN
  output logic [32*NUM_SENSORS-1:0] status,
`endif
  output logic [NUM_SENSORS-1:0]    valid,
  output logic [NUM_SENSORS-1:0]    error,
  output logic                      sweep_done,
  output logic                      busy,
  output logic                      i2c_ena,
  output logic [6:0]                i2c_addr,
  output logic                      i2c_rw,
  output logic [31:0]               i2c_data_wd,
  output logic [7:0]                i2c_number_of_bytes,
  input  logic                      i2c_busy,
  input  logic [7:0]                i2c_byte_counter,
  input  logic [31:0]               i2c_data_rd,
  input  logic                      i2c_ack_error
);
  localparam int IDX_W = $clog2(NUM_SENSORS + 1);
  localparam int PER_W = $clog2(POLL_PERIOD + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(NUM_SENSORS);
  localparam logic [PER_W-1:0] PER_RELOAD = PER_W'(POLL_PERIOD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, ISSUE, WAIT_START, WAIT_END, CAPTURE, DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_SENSORS-1:0]      mask_q, mask_d;
  logic [PER_W-1:0]            per_q, per_d;
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  logic [16*NUM_SENSORS-1:0]   angles_q, angles_d;
  logic [NUM_SENSORS-1:0]      valid_q, valid_d;
  logic [NUM_SENSORS-1:0]      error_q, error_d;
  logic                        done_q, done_d;
  logic                        busy_q, busy_d;
  logic                        ena_q, ena_d;
  logic [6:0]                  addr_q, addr_d;
  logic                        rw_q, rw_d;
  logic [31:0]                 wd_q, wd_d;
  logic [7:0]                  nbytes_q, nbytes_d;
  logic [NUM_SENSORS-1:0]      cur_oh;
  logic [6:0]                  cur_id;
  logic [7:0]                  reg_sel;

`ifdef A1335_STATUS_READ_EN
  logic                        phase_q, phase_d;
  logic [32*NUM_SENSORS-1:0]   status_q, status_d;
  assign reg_sel = phase_q ? STATUS_REG : ANGLE_REG;
  assign status  = status_q;
`else
  logic unused_rd;
  assign reg_sel   = ANGLE_REG;
  assign unused_rd = ^{i2c_data_rd[15:0], STATUS_REG};
`endif

  always_comb begin
    cur_oh = NUM_SENSORS'(1) << idx_q;
    cur_id = '0;
    for (int k = 0; k < NUM_SENSORS; k++)
      if (cur_oh[k]) cur_id = device_ids[7*k +: 7];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    per_d    = (per_q != '0) ? per_q - PER_W'(1) : per_q;
    tmo_d    = tmo_q;
    angles_d = angles_q;
    valid_d  = valid_q;
    error_d  = error_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    ena_d    = ena_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    wd_d     = wd_q;
    nbytes_d = nbytes_q;
`ifdef A1335_STATUS_READ_EN
    phase_d  = phase_q;
    status_d = status_q;
`endif
    // The master latches the command on its own; ena only has to cover the byte count.
    if (ena_q && (i2c_byte_counter >= nbytes_q)) ena_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (trigger || (free_run && per_q == '0)) begin
          mask_d  = sensor_mask;
          idx_d   = '0;
          per_d   = PER_RELOAD;
          busy_d  = 1'b1;
          state_d = SELECT;
`ifdef A1335_STATUS_READ_EN
          phase_d = 1'b0;
`endif
        end
      end
      SELECT: begin
        if (idx_q >= IDX_END) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if ((mask_q & cur_oh) == '0) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A transfer abandoned by timeout may still be running on the bus.
        if (!i2c_busy) begin
          addr_d   = cur_id;
          rw_d     = 1'b1;
          nbytes_d = 8'd3;
          wd_d     = {reg_sel, 24'h0};
          ena_d    = 1'b1;
          tmo_d    = '0;
          state_d  = WAIT_START;
        end
      end
      WAIT_START, WAIT_END: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (tmo_q == TMO_LAST) begin
          error_d = error_q | cur_oh;
          ena_d   = 1'b0;
          idx_d   = idx_q + IDX_W'(1);
          state_d = SELECT;
`ifdef A1335_STATUS_READ_EN
          phase_d = 1'b0;
`endif
        end else if (state_q == WAIT_START) begin
          if (i2c_busy) state_d = WAIT_END;
        end else if (!i2c_busy && !ena_q) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (i2c_ack_error) begin
          error_d = error_q | cur_oh;
        end else begin
          error_d = error_q & ~cur_oh;
          for (int k = 0; k < NUM_SENSORS; k++) begin
`ifdef A1335_STATUS_READ_EN
            if (cur_oh[k] && phase_q) status_d[32*k +: 32] = i2c_data_rd;
            if (cur_oh[k] && !phase_q) begin
`else
            if (cur_oh[k]) begin
`endif
              angles_d[16*k +: 16] = i2c_data_rd[31:16];
              valid_d[k]           = 1'b1;
            end
          end
        end
`ifdef A1335_STATUS_READ_EN
        if (!phase_q) begin
          phase_d = 1'b1;
          state_d = ISSUE;
        end else begin
          phase_d = 1'b0;
          idx_d   = idx_q + IDX_W'(1);
          state_d = SELECT;
        end
`else
        idx_d   = idx_q + IDX_W'(1);
        state_d = SELECT;
`endif
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      mask_q   <= '0;
      per_q    <= '0;
      tmo_q    <= '0;
      angles_q <= '0;
      valid_q  <= '0;
      error_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ena_q    <= 1'b0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      wd_q     <= '0;
      nbytes_q <= '0;
`ifdef A1335_STATUS_READ_EN
      phase_q  <= 1'b0;
      status_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      per_q    <= per_d;
      tmo_q    <= tmo_d;
      angles_q <= angles_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ena_q    <= ena_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      wd_q     <= wd_d;
      nbytes_q <= nbytes_d;
`ifdef A1335_STATUS_READ_EN
      phase_q  <= phase_d;
      status_q <= status_d;
`endif
    end
  end

  assign angles              = angles_q;
  assign valid               = valid_q;
  assign error               = error_q;
  assign sweep_done          = done_q;
  assign busy                = busy_q;
  assign i2c_ena             = ena_q;
  assign i2c_addr            = addr_q;
  assign i2c_rw              = rw_q;
  assign i2c_data_wd         = wd_q;
  assign i2c_number_of_bytes = nbytes_q;
endmodule

// File: tb/tb_a1335_poll_array.sv
// Scoreboard bench for a1335_poll_array with a behavioural i2c_master model.
module tb_a1335_poll_array;
  localparam int N      = 4;
  localparam int PERIOD = 1000;
  localparam int TMO    = 20000;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             free_run = 1'b0;
  logic             trigger = 1'b0;
  logic [N-1:0]     sensor_mask = '1;
  logic [7*N-1:0]   device_ids = {7'h13, 7'h12, 7'h11, 7'h10};
  logic [16*N-1:0]  angles;
`ifdef A1335_STATUS_READ_EN
  logic [32*N-1:0]  status;
`endif
  logic [N-1:0]     valid, error;
  logic             sweep_done, busy;
  logic             i2c_ena, i2c_rw;
  logic [6:0]       i2c_addr;
  logic [31:0]      i2c_data_wd;
  logic [7:0]       i2c_number_of_bytes;
  logic             i2c_busy, i2c_ack_error;
  logic [7:0]       i2c_byte_counter;
  logic [31:0]      i2c_data_rd;

  a1335_poll_array #(
    .NUM_SENSORS(N), .POLL_PERIOD(PERIOD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .free_run(free_run), .trigger(trigger),
    .sensor_mask(sensor_mask), .device_ids(device_ids), .angles(angles),
`ifdef A1335_STATUS_READ_EN
    .status(status),
`endif
    .valid(valid), .error(error), .sweep_done(sweep_done), .busy(busy),
    .i2c_ena(i2c_ena), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw),
    .i2c_data_wd(i2c_data_wd), .i2c_number_of_bytes(i2c_number_of_bytes),
    .i2c_busy(i2c_busy), .i2c_byte_counter(i2c_byte_counter),
    .i2c_data_rd(i2c_data_rd), .i2c_ack_error(i2c_ack_error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // i2c_master model: busy 2 cycles after ena, one byte every 3 cycles, response on busy fall
  logic [6:0]  hang_addr = 7'h7F;
  logic [6:0]  nack_addr = 7'h7F;
  logic [15:0] resp_base = 16'h0;
  logic        m_act;
  int          m_cnt;
  logic [6:0]  m_addr;
  logic [7:0]  m_reg;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_act <= 1'b0; m_cnt <= 0; m_addr <= '0; m_reg <= '0;
      i2c_busy <= 1'b0; i2c_byte_counter <= '0; i2c_data_rd <= '0; i2c_ack_error <= 1'b0;
    end else if (!m_act) begin
      i2c_byte_counter <= '0;
      if (i2c_ena && i2c_addr != hang_addr) begin
        m_act <= 1'b1; m_cnt <= 0; m_addr <= i2c_addr; m_reg <= i2c_data_wd[31:24];
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 1) i2c_busy <= 1'b1;
      if (m_cnt == 4 || m_cnt == 7 || m_cnt == 10) i2c_byte_counter <= i2c_byte_counter + 8'd1;
      if (m_cnt == 13) begin
        i2c_busy      <= 1'b0;
        m_act         <= 1'b0;
        i2c_ack_error <= (m_addr == nack_addr);
        i2c_data_rd   <= (m_reg == 8'h22) ? 32'hDEAD0000 + 32'(m_addr - 7'h10)
                                          : {resp_base + 16'(m_addr - 7'h10), 16'h0};
      end
    end
  end

  typedef struct {
    logic [16*N-1:0] ang;
    logic [N-1:0]    val;
    logic [N-1:0]    err;
    logic [32*N-1:0] st;
  } sweep_t;

  logic [38:0]     exp_tx[$];
  sweep_t          exp_sw[$];
  int              done_cyc[$];
  logic [32*N-1:0] exp_stat = '0;
  int n_cmp = 0, n_err = 0;
  int done_cnt = 0, hang_len = 0, ena_run = 0;
  logic ena_prev = 1'b0, done_prev = 1'b0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  // Monitor: pops expectations whenever the DUT starts a transaction or ends a sweep.
  always @(negedge clock) begin
    logic [38:0] t;
    sweep_t s;
    if (reset) begin
      ena_prev = 1'b0; done_prev = 1'b0; ena_run = 0;
    end else begin
      if (i2c_ena && !ena_prev) begin
        if (exp_tx.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_tx: addr 0x%0h, required no transaction", i2c_addr);
        end else begin
          t = exp_tx.pop_front();
          check("tx_addr", 128'(i2c_addr), 128'(t[38:32]));
          check("tx_data_wd", 128'(i2c_data_wd), 128'(t[31:0]));
          check("tx_rw_nbytes", 128'({i2c_rw, i2c_number_of_bytes}), 128'({1'b1, 8'd3}));
        end
      end
      if (i2c_ena) ena_run++;
      else if (ena_prev) begin
        if (i2c_addr == hang_addr) hang_len = ena_run;
        ena_run = 0;
      end
      if (sweep_done) begin
        check("done_single_cycle", 128'(done_prev), 128'(0));
        check("busy_at_done", 128'(busy), 128'(1));
        if (exp_sw.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_sweep: sweep_done at cycle %0d, required none", cyc);
        end else begin
          s = exp_sw.pop_front();
          check("angles", 128'(angles), 128'(s.ang));
          check("valid", 128'(valid), 128'(s.val));
          check("error", 128'(error), 128'(s.err));
`ifdef A1335_STATUS_READ_EN
          check("status", 128'(status), 128'(s.st));
`endif
        end
        done_cnt++;
        done_cyc.push_back(cyc);
      end
      ena_prev  = i2c_ena;
      done_prev = sweep_done;
    end
  end

  task automatic push_sweep(input logic [N-1:0] m, input int nack_k, input int hang_k,
                            input logic [16*N-1:0] ang, input logic [N-1:0] v, input logic [N-1:0] e);
    sweep_t s;
    nack_addr = (nack_k < 0) ? 7'h7F : 7'(7'h10 + nack_k);
    hang_addr = (hang_k < 0) ? 7'h7F : 7'(7'h10 + hang_k);
    for (int k = 0; k < N; k++) begin
      if (m[k]) begin
        exp_tx.push_back({7'(7'h10 + k), 8'h20, 24'h0});
`ifdef A1335_STATUS_READ_EN
        if (k != hang_k) begin
          exp_tx.push_back({7'(7'h10 + k), 8'h22, 24'h0});
          if (k != nack_k) exp_stat[32*k +: 32] = 32'hDEAD0000 + 32'(k);
        end
`endif
      end
    end
    s.ang = ang; s.val = v; s.err = e; s.st = exp_stat;
    exp_sw.push_back(s);
  endtask

  task automatic wait_done(input int target, input int budget, input string nm);
    int c = 0;
    while (done_cnt < target && c < budget) begin
      @(posedge clock);
      c++;
    end
    if (done_cnt < target) begin
      n_cmp++; n_err++;
      $display("FAIL %s: sweep_done count %0d, required %0d within %0d cycles", nm, done_cnt, target, budget);
    end
  endtask

  task automatic pulse_trigger();
    @(posedge clock); #1 trigger = 1'b1;
    @(posedge clock); #1 trigger = 1'b0;
  endtask

  task automatic run(input logic [N-1:0] m, input logic [15:0] base, input int nack_k, input int hang_k,
                     input logic [16*N-1:0] ang, input logic [N-1:0] v, input logic [N-1:0] e,
                     input int budget, input string nm);
    int target;
    target = done_cnt + 1;
    push_sweep(m, nack_k, hang_k, ang, v, e);
    resp_base   = base;
    sensor_mask = m;
    pulse_trigger();
    wait_done(target, budget, nm);
  endtask

  initial begin
    int base_i, target, c;
    repeat (3) @(posedge clock);
    #1;
    check("rst_angles", 128'(angles), 128'(0));
    check("rst_valid", 128'(valid), 128'(0));
    check("rst_error", 128'(error), 128'(0));
    check("rst_done_busy", 128'({sweep_done, busy}), 128'(0));
    check("rst_ena_rw", 128'({i2c_ena, i2c_rw}), 128'(0));
    check("rst_addr", 128'(i2c_addr), 128'(0));
    check("rst_data_wd", 128'(i2c_data_wd), 128'(0));
    check("rst_nbytes", 128'(i2c_number_of_bytes), 128'(0));
    @(negedge clock) reset = 1'b0;

    // Triggered full sweep with start-latency checks and an ignored mid-sweep trigger
    push_sweep(4'hF, -1, -1, 64'h1003_1002_1001_1000, 4'hF, 4'h0);
    resp_base = 16'h1000;
    @(posedge clock); #1 trigger = 1'b1;
    @(posedge clock); #1 trigger = 1'b0;
    check("latency_busy_t1", 128'(busy), 128'(1));
    check("latency_ena_t1", 128'(i2c_ena), 128'(0));
    @(posedge clock); #1 check("latency_ena_t2", 128'(i2c_ena), 128'(0));
    @(posedge clock); #1 check("latency_ena_t3", 128'(i2c_ena), 128'(1));
    repeat (20) @(posedge clock);
    pulse_trigger();
    wait_done(1, 500, "sweep1");

    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    exp_stat = '0;
    run(4'b0101, 16'h2000, -1, -1, 64'h0000_2002_0000_2000, 4'b0101, 4'h0, 500, "mask");
    run(4'hF, 16'h3000, -1, -1, 64'h3003_3002_3001_3000, 4'hF, 4'h0, 500, "full");
    run(4'hF, 16'h4000, 1, -1, 64'h4003_4002_3001_4000, 4'hF, 4'b0010, 500, "nack");
    run(4'hF, 16'h5000, -1, -1, 64'h5003_5002_5001_5000, 4'hF, 4'h0, 500, "nack_clear");
    run(4'hF, 16'h6000, -1, 2, 64'h6003_5002_6001_6000, 4'hF, 4'b0100, 30000, "timeout");
    check("timeout_ena_cycles", 128'(hang_len), 128'(TMO));

    // Free-run: four sweeps of sensor 0 one period apart
    base_i = done_cyc.size();
    target = done_cnt + 4;
    for (int i = 0; i < 4; i++)
      push_sweep(4'b0001, -1, -1, 64'h6003_5002_6001_7000, 4'hF, 4'b0100);
    resp_base   = 16'h7000;
    sensor_mask = 4'b0001;
    free_run    = 1'b1;
    wait_done(target, 5000, "free_run");
    free_run = 1'b0;
    for (int i = 1; i < 4; i++)
      if (done_cyc.size() > base_i + i)
        check("free_run_period", 128'(done_cyc[base_i+i] - done_cyc[base_i+i-1]), 128'(PERIOD));

    // Reset while the master is busy (WAIT_END)
    exp_tx.push_back({7'h10, 8'h20, 24'h0});
    resp_base = 16'h9000;
    pulse_trigger();
    c = 0;
    while (!i2c_busy && c < 200) begin
      @(posedge clock);
      c++;
    end
    check("reached_wait_end", 128'(i2c_busy), 128'(1));
    @(posedge clock); #2 reset = 1'b1;
    #1;
    check("midrst_ena", 128'(i2c_ena), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_angles", 128'(angles), 128'(0));
    check("midrst_valid_error", 128'({valid, error}), 128'(0));
    repeat (3) @(negedge clock);
    reset    = 1'b0;
    exp_stat = '0;
    target   = done_cnt + 1;
    push_sweep(4'hF, -1, -1, 64'h8003_8002_8001_8000, 4'hF, 4'h0);
    resp_base   = 16'h8000;
    sensor_mask = 4'hF;
    free_run    = 1'b1;
    wait_done(target, 500, "resume");
    free_run = 1'b0;

    repeat (50) @(posedge clock);
    check("tx_queue_empty", 128'(exp_tx.size()), 128'(0));
    check("sweep_queue_empty", 128'(exp_sw.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end
endmodule
